// File: rtl/sw_cond_pkg.sv
// Shared defaults and sizing helpers for the slide-switch input conditioner.
package sw_cond_pkg;

  localparam int SW_NUM_DEFAULT        = 18;
  localparam int SW_TICK_DIV_DEFAULT   = 50000;
  localparam int SW_STABLE_CNT_DEFAULT = 8;

  function automatic int sw_cnt_width(input int stable);
    int w;
    w = $clog2(stable);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch line: debounced state, run counter and edge pulses.
module sw_debounce_bit
  import sw_cond_pkg::*;
#(
  parameter int STABLE_CNT = SW_STABLE_CNT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic sync_i,
  output logic state_o,
  output logic rise_o,
  output logic fall_o,
  output logic pend_o
);

  localparam int CW = sw_cnt_width(STABLE_CNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          state_q, state_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (tick_i) begin
      if (sync_i == state_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        // disagreement held long enough: commit and pulse
        state_d = sync_i;
        cnt_d   = '0;
        rise_d  = sync_i;
        fall_d  = ~sync_i;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      state_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign state_o = state_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign pend_o  = |cnt_q;

endmodule

// File: rtl/sw_input_cond.sv
// Slide-switch conditioner: 2-flop sync, shared tick, per-bit debounce,
// zero-extended switch word and edge pulses for the core's input port.
module sw_input_cond
  import sw_cond_pkg::*;
#(
  parameter int NUM_SW     = SW_NUM_DEFAULT,
  parameter int TICK_DIV   = SW_TICK_DIV_DEFAULT,
  parameter int STABLE_CNT = SW_STABLE_CNT_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NUM_SW-1:0] sw_raw_i,
  output logic [31:0]       io_sw_o,
  output logic [NUM_SW-1:0] sw_rise_o,
  output logic [NUM_SW-1:0] sw_fall_o,
  output logic              sw_changed_o,
  output logic              busy_o
);

  localparam int TW = (TICK_DIV <= 1) ? 1 : $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [NUM_SW-1:0] sync1_q, sync1_d;
  logic [NUM_SW-1:0] sync2_q, sync2_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              busy_q, busy_d;
  logic              tick;
  logic [NUM_SW-1:0] state;
  logic [NUM_SW-1:0] pend;

  assign tick = (tcnt_q == TICK_LAST);

  always_comb begin
    sync1_d = sw_raw_i;
    sync2_d = sync1_q;
    tcnt_d  = tick ? '0 : tcnt_q + 1'b1;
    busy_d  = |pend;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
      tcnt_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      tcnt_q  <= tcnt_d;
      busy_q  <= busy_d;
    end
  end

  for (genvar i = 0; i < NUM_SW; i++) begin : g_bit
    sw_debounce_bit #(
      .STABLE_CNT(STABLE_CNT)
    ) u_bit (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .tick_i (tick),
      .sync_i (sync2_q[i]),
      .state_o(state[i]),
      .rise_o (sw_rise_o[i]),
      .fall_o (sw_fall_o[i]),
      .pend_o (pend[i])
    );
  end

  always_comb begin
    io_sw_o             = '0;
    io_sw_o[NUM_SW-1:0] = state;
  end

  assign sw_changed_o = |(sw_rise_o | sw_fall_o);
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_sw_input_cond.sv
// Randomised and directed bench for sw_input_cond against a tick/run model.
module tb_sw_input_cond;

  localparam int NSW = 4;
  localparam int TD  = 4;
  localparam int SC  = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [NSW-1:0] sw_raw = '0;
  logic [31:0]    io_sw;
  logic [NSW-1:0] rise, fall;
  logic           changed, busy;

  always #5 clk = ~clk;

  sw_input_cond #(
    .NUM_SW    (NSW),
    .TICK_DIV  (TD),
    .STABLE_CNT(SC)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .sw_raw_i    (sw_raw),
    .io_sw_o     (io_sw),
    .sw_rise_o   (rise),
    .sw_fall_o   (fall),
    .sw_changed_o(changed),
    .busy_o      (busy)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // model: edges since reset, raw history, consecutive disagreeing ticks
  int             m_edge;
  int             m_run[NSW];
  logic [NSW-1:0] m_st, m_rise, m_fall;
  logic           m_busy;
  logic [NSW-1:0] m_hist[$];

  task automatic model_reset();
    m_edge = 0;
    m_st   = '0;
    m_rise = '0;
    m_fall = '0;
    m_busy = 1'b0;
    m_hist.delete();
    for (int i = 0; i < NSW; i++) m_run[i] = 0;
  endtask

  task automatic model_edge();
    logic [NSW-1:0] seen;
    bit pending;
    seen = (m_hist.size() >= 2) ? m_hist[m_hist.size()-2] : '0;
    pending = 0;
    for (int i = 0; i < NSW; i++) if (m_run[i] != 0) pending = 1;
    m_busy = pending;
    m_rise = '0;
    m_fall = '0;
    if (m_edge % TD == TD - 1) begin
      for (int i = 0; i < NSW; i++) begin
        if (seen[i] != m_st[i]) begin
          m_run[i]++;
          if (m_run[i] == SC) begin
            m_st[i]  = seen[i];
            m_run[i] = 0;
            if (seen[i]) m_rise[i] = 1'b1;
            else         m_fall[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
    m_hist.push_back(sw_raw);
    if (m_hist.size() > 3) void'(m_hist.pop_front());
    m_edge++;
  endtask

  task automatic cyc(input logic [NSW-1:0] nxt);
    @(posedge clk);
    if (rst_n) model_edge();
    #1 sw_raw = nxt;
    @(negedge clk);
    if (rst_n) begin
      chk("io",      io_sw,   {28'h0, m_st});
      chk("rise",    rise,    m_rise);
      chk("fall",    fall,    m_fall);
      chk("changed", changed, |(m_rise | m_fall));
      chk("busy",    busy,    m_busy);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_io"},   io_sw,   32'h0);
    chk({tag, "_rise"}, rise,    '0);
    chk({tag, "_fall"}, fall,    '0);
    chk({tag, "_chg"},  changed, 1'b0);
    chk({tag, "_busy"}, busy,    1'b0);
  endtask

  initial begin
    int n, cnt, pos;
    bit hit, bad;
    logic [NSW-1:0] r;

    model_reset();
    #1 rst_n = 1'b0;
    #1 chk_zero("rst");
    repeat (3) cyc('0);
    rst_n = 1'b1;

    // 1: idle after reset
    repeat (50) cyc('0);
    chk_zero("idle");

    // 2: clean rise on bit 0
    cyc(4'b0001);
    n = 0;
    hit = 0;
    while (n < 30 && !hit) begin
      cyc(4'b0001);
      n++;
      hit = io_sw[0];
    end
    chk("t2_seen", hit, 1'b1);
    chk("t2_lat", (n >= 11 && n <= 15), 1'b1);
    chk("t2_rise", rise, 4'b0001);
    chk("t2_chg", changed, 1'b1);
    cyc(4'b0001);
    chk("t2_rise_1cyc", rise, 4'b0000);

    // 3: 6-cycle glitch on bit 1 is discarded
    hit = 0;
    repeat (6) begin
      cyc(4'b0011);
      hit |= rise[1] | fall[1];
    end
    repeat (25) begin
      cyc(4'b0001);
      hit |= rise[1] | fall[1] | io_sw[1];
    end
    chk("t3_nopulse", hit, 1'b0);
    chk("t3_io", io_sw, 32'h1);
    chk("t3_busy", busy, 1'b0);

    // 4: bit2 up and bit0 down together
    cyc(4'b0100);
    cnt = 0;
    bad = 0;
    hit = 0;
    repeat (30) begin
      cyc(4'b0100);
      if (changed) begin
        cnt++;
        hit = (rise == 4'b0100) && (fall == 4'b0001) && (io_sw == 32'h4);
      end
      if (io_sw != 32'h1 && io_sw != 32'h4) bad = 1;
    end
    chk("t4_pulses", cnt, 1);
    chk("t4_same_edge", hit, 1'b1);
    chk("t4_no_mid", bad, 1'b0);
    chk("t4_io", io_sw, 32'h4);

    // 5: reset while a transition is pending
    cyc(4'b0010);
    n = 0;
    while (n < 20 && !busy) begin
      cyc(4'b0010);
      n++;
    end
    chk("t5_busy_seen", busy, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("t5_async");
    model_reset();
    repeat (3) cyc('0);
    rst_n = 1'b1;
    cnt = 0;
    repeat (30) begin
      cyc('0);
      if (changed) cnt++;
    end
    chk("t5_nopulse", cnt, 0);

    // 6: bounce train on bit 3 then settle high
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      cyc({((k / 3) % 2 == 0), 3'b000});
      if (rise[3]) cnt++;
    end
    chk("t6_bounce_quiet", cnt, 0);
    pos = -1;
    for (int k = 0; k < 25; k++) begin
      cyc(4'b1000);
      if (rise[3]) begin
        cnt++;
        pos = k;
      end
    end
    chk("t6_one_rise", cnt, 1);
    chk("t6_window", (pos >= 1 && pos <= 15), 1'b1);
    chk("t6_io", io_sw, 32'h8);

    // random hold/glitch traffic checked every cycle
    r = sw_raw;
    repeat (800) begin
      if ($urandom_range(0, 9) == 0)
        r[$urandom_range(0, NSW-1)] ^= 1'b1;
      cyc(r);
    end
    repeat (40) cyc(r);
    chk("rand_settled", io_sw, {28'h0, r});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
